// File: rtl/branch_hazard_unit.sv
// ID-stage branch controller: stalls on rs/rt hazards, then resolves the branch.
// Drives PC select, branch target and IF/ID flush, and counts taken branches.
module branch_hazard_unit #(
    parameter int PCBITS  = 32,
    parameter int REGBITS = 5,
    parameter int CNTBITS = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_branch,
    input  logic               i_branch_ne,
    input  logic [REGBITS-1:0] i_rs_addr,
    input  logic [REGBITS-1:0] i_rt_addr,
    input  logic               i_zero,
    input  logic               i_ex_regwrite,
    input  logic               i_ex_memread,
    input  logic [REGBITS-1:0] i_ex_rd,
    input  logic               i_mem_memread,
    input  logic [REGBITS-1:0] i_mem_rd,
    input  logic [PCBITS-1:0]  i_pc_plus4,
    input  logic [PCBITS-1:0]  i_imm,
    output logic               o_stall,
    output logic               o_bubble,
    output logic               o_pc_src,
    output logic               o_if_id_flush,
    output logic [PCBITS-1:0]  o_branch_target,
    output logic [CNTBITS-1:0] o_taken_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STALL   = 2'd1,
        S_RESOLVE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_scnt;
    logic [1:0]         w_scnt_nxt;
    logic [CNTBITS-1:0] r_taken_cnt;

    logic w_br;
    logic w_ex_match;
    logic w_mem_match;
    logic w_hexl;
    logic w_hexa;
    logic w_hmem;
    logic w_stall;
    logic w_resolve;
    logic w_taken;

    assign w_br = i_branch | i_branch_ne;

    // Register 0 is hard-wired, so a write to it is never a real dependency.
    assign w_ex_match  = (i_ex_rd != '0) &&
                         ((i_ex_rd == i_rs_addr) || (i_ex_rd == i_rt_addr));
    assign w_mem_match = (i_mem_rd != '0) &&
                         ((i_mem_rd == i_rs_addr) || (i_mem_rd == i_rt_addr));

    assign w_hexl = i_ex_regwrite & i_ex_memread & w_ex_match;
    assign w_hexa = i_ex_regwrite & ~i_ex_memread & w_ex_match;
    assign w_hmem = i_mem_memread & w_mem_match;

    always_comb begin
        w_state_nxt = r_state;
        w_scnt_nxt  = r_scnt;
        w_stall     = 1'b0;
        w_resolve   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_br) begin
                    if (w_hexl) begin
                        w_stall     = 1'b1;
                        w_scnt_nxt  = 2'd1;
                        w_state_nxt = S_STALL;
                    end else if (w_hexa || w_hmem) begin
                        w_stall     = 1'b1;
                        w_state_nxt = S_RESOLVE;
                    end else begin
                        w_resolve = 1'b1;
                    end
                end
            end
            S_STALL: begin
                if (!w_br) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_stall    = 1'b1;
                    w_scnt_nxt = r_scnt - 2'd1;
                    if (r_scnt == 2'd1) begin
                        w_state_nxt = S_RESOLVE;
                    end
                end
            end
            S_RESOLVE: begin
                w_resolve   = w_br;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // BEQ wins when both branch flavours are asserted.
    assign w_taken = w_resolve & (i_branch ? i_zero : ~i_zero);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_scnt      <= 2'd0;
            r_taken_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_scnt  <= w_scnt_nxt;
            if (w_taken) begin
                r_taken_cnt <= r_taken_cnt + CNTBITS'(1);
            end
        end
    end

    assign o_stall         = w_stall & i_rst_n;
    assign o_bubble        = w_stall & i_rst_n;
    assign o_pc_src        = w_taken & i_rst_n;
    assign o_if_id_flush   = w_taken & i_rst_n;
    assign o_branch_target = i_pc_plus4 + (i_imm << 2);
    assign o_taken_cnt     = r_taken_cnt;

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Bench for branch_hazard_unit: a per-branch stall-budget model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_branch_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        b = 1'b0, bn = 1'b0, z = 1'b0;
    logic [4:0]  rs = '0, rt = '0, exrd = '0, mrd = '0;
    logic        exw = 1'b0, exm = 1'b0, mm = 1'b0;
    logic [31:0] pc4 = '0, imm = '0;

    logic        stall, bubble, pc_src, flush;
    logic [31:0] target;
    logic [15:0] cnt;
    logic        stall4, bubble4, pc_src4, flush4;
    logic [31:0] target4;
    logic [3:0]  cnt4;

    int passed = 0;
    int total  = 0;

    // model state: branch in flight and stall cycles it still owes
    bit inflight = 0, n_inflight = 0;
    int rem = 0, n_rem = 0;
    int mcnt = 0, n_mcnt = 0;

    branch_hazard_unit dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_branch(b), .i_branch_ne(bn),
        .i_rs_addr(rs), .i_rt_addr(rt), .i_zero(z),
        .i_ex_regwrite(exw), .i_ex_memread(exm), .i_ex_rd(exrd),
        .i_mem_memread(mm), .i_mem_rd(mrd), .i_pc_plus4(pc4), .i_imm(imm),
        .o_stall(stall), .o_bubble(bubble), .o_pc_src(pc_src),
        .o_if_id_flush(flush), .o_branch_target(target), .o_taken_cnt(cnt)
    );

    branch_hazard_unit #(.CNTBITS(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_branch(b), .i_branch_ne(bn),
        .i_rs_addr(rs), .i_rt_addr(rt), .i_zero(z),
        .i_ex_regwrite(exw), .i_ex_memread(exm), .i_ex_rd(exrd),
        .i_mem_memread(mm), .i_mem_rd(mrd), .i_pc_plus4(pc4), .i_imm(imm),
        .o_stall(stall4), .o_bubble(bubble4), .o_pc_src(pc_src4),
        .o_if_id_flush(flush4), .o_branch_target(target4), .o_taken_cnt(cnt4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int stalls_needed();
        bit mex, mmem;
        mex  = (exrd != 0) && (exrd == rs || exrd == rt);
        mmem = (mrd != 0) && (mrd == rs || mrd == rt);
        if (exw && exm && mex) return 2;
        if ((exw && !exm && mex) || (mm && mmem)) return 1;
        return 0;
    endfunction

    // compare process: expectations from the stall-budget model, away from the active edge
    always @(negedge clk) begin
        bit e_st, e_res, e_tk;
        int s;
        logic [31:0] e_tgt;
        e_st = 0; e_res = 0;
        n_inflight = inflight; n_rem = rem; n_mcnt = mcnt;
        if (!rst_n) begin
            mcnt = 0; n_mcnt = 0; n_inflight = 0; n_rem = 0;
        end else if (!inflight) begin
            if (b || bn) begin
                s = stalls_needed();
                if (s > 0) begin e_st = 1; n_inflight = 1; n_rem = s - 1; end
                else e_res = 1;
            end
        end else if (!(b || bn)) begin
            n_inflight = 0;
        end else if (rem > 0) begin
            e_st = 1; n_rem = rem - 1;
        end else begin
            e_res = 1; n_inflight = 0;
        end
        e_tk = e_res && (b ? z : !z);
        if (e_tk) n_mcnt = mcnt + 1;
        e_tgt = pc4 + imm * 4;
        chk("stall",   {31'd0, stall},   {31'd0, e_st});
        chk("bubble",  {31'd0, bubble},  {31'd0, e_st});
        chk("pc_src",  {31'd0, pc_src},  {31'd0, e_tk});
        chk("flush",   {31'd0, flush},   {31'd0, e_tk});
        chk("target",  target, e_tgt);
        chk("cnt",     {16'd0, cnt},  32'(mcnt % 65536));
        chk("stall4",  {31'd0, stall4},  {31'd0, e_st});
        chk("pc_src4", {31'd0, pc_src4}, {31'd0, e_tk});
        chk("cnt4",    {28'd0, cnt4}, 32'(mcnt % 16));
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            inflight = 0; rem = 0; mcnt = 0;
        end else begin
            inflight = n_inflight; rem = n_rem; mcnt = n_mcnt;
        end
    end

    task automatic set_in(input logic ib, input logic ibn, input logic [4:0] irs, input logic [4:0] irt,
                          input logic iz, input logic iexw, input logic iexm, input logic [4:0] iexrd,
                          input logic imm_rd, input logic [4:0] imrd);
        b = ib; bn = ibn; rs = irs; rt = irt; z = iz;
        exw = iexw; exm = iexm; exrd = iexrd; mm = imm_rd; mrd = imrd;
        #2;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int nst;
        #2;
        chk("reset stall", {31'd0, stall}, 32'd0);
        chk("reset cnt", {16'd0, cnt}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 1: BEQ taken, no hazard
        pc4 = 32'h104; imm = 32'd3;
        set_in(1, 0, 5'd1, 5'd4, 1, 0, 0, 0, 0, 0);
        chk("t1 pc_src", {31'd0, pc_src}, 32'd1);
        chk("t1 flush", {31'd0, flush}, 32'd1);
        chk("t1 target", target, 32'h110);
        chk("t1 stall", {31'd0, stall}, 32'd0);
        tick(); idle();
        chk("t1 cnt", {16'd0, cnt}, 32'd1);
        tick();

        // 2: load-use, then load in MEM: exactly two stalls, third cycle resolves
        nst = 0;
        set_in(1, 0, 5'd2, 5'd7, 1, 1, 1, 5'd2, 0, 0);
        nst += int'(stall); tick();
        set_in(1, 0, 5'd2, 5'd7, 1, 0, 0, 0, 1, 5'd2);
        nst += int'(stall); tick();
        set_in(1, 0, 5'd2, 5'd7, 1, 0, 0, 0, 1, 5'd2);
        nst += int'(stall);
        chk("t2 stalls", 32'(nst), 32'd2);
        chk("t2 resolve", {31'd0, pc_src}, 32'd1);
        tick(); idle(); tick();

        // 3: ALU hazard on rt, BNE not taken
        set_in(0, 1, 5'd9, 5'd3, 1, 1, 0, 5'd3, 0, 0);
        chk("t3 stall", {31'd0, stall}, 32'd1);
        tick();
        set_in(0, 1, 5'd9, 5'd3, 1, 0, 0, 0, 0, 0);
        chk("t3 stall2", {31'd0, stall}, 32'd0);
        chk("t3 pc_src", {31'd0, pc_src}, 32'd0);
        tick(); idle();
        chk("t3 cnt", {16'd0, cnt}, 32'd2);
        tick();

        // 4: write to r0 is not a hazard
        set_in(1, 0, 5'd0, 5'd0, 1, 1, 0, 5'd0, 0, 0);
        chk("t4 stall", {31'd0, stall}, 32'd0);
        chk("t4 pc_src", {31'd0, pc_src}, 32'd1);
        tick(); idle(); tick();

        // 5: reset while stalling, then fresh detection
        set_in(1, 0, 5'd6, 5'd1, 1, 1, 1, 5'd6, 0, 0);
        tick();
        chk("t5 in stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0; #1;
        chk("t5 rst stall", {31'd0, stall}, 32'd0);
        chk("t5 rst cnt", {16'd0, cnt}, 32'd0);
        tick(); rst_n = 1'b1; #1;
        nst = 0;
        nst += int'(stall); tick();
        nst += int'(stall); tick();
        chk("t5 pc_src", {31'd0, pc_src}, 32'd1);
        chk("t5 stalls", 32'(nst), 32'd2);
        tick(); idle(); tick();

        // 6: branch dropped during STALL, then counter wrap on the 4-bit instance
        set_in(1, 0, 5'd6, 5'd1, 1, 1, 1, 5'd6, 0, 0);
        tick();
        idle();
        chk("t6 squash", {31'd0, pc_src | stall}, 32'd0);
        tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
        for (int i = 0; i < 16; i++) begin
            set_in(1, 0, 5'd1, 5'd2, 1, 0, 0, 0, 0, 0);
            tick();
        end
        idle();
        chk("t6 cnt4 wrap", {28'd0, cnt4}, 32'd0);
        chk("t6 cnt16", {16'd0, cnt}, 32'd16);
        tick(); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
